// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: stores to the I/O word are queued in a small
// FIFO and shifted out as 8N1 frames on a registered tx line.
module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int BUS_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          io_wr_en,
    input  logic [BUS_WIDTH-1:0]          io_wr_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_next;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [BAUD_W-1:0] baud, baud_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [7:0]        shift_reg, shift_next;
    logic              tx_next;
    logic              pop, push, baud_done;
    logic              unused_upper;

    // A full FIFO still accepts a write on the edge the FSM pops the head.
    assign pop       = (state == IDLE) && (fifo_count != '0);
    assign push      = io_wr_en && ((fifo_count != DEPTH) || pop);
    assign baud_done = (baud == BAUD_LAST);

    assign busy         = (state != IDLE) || (fifo_count != '0);
    assign fifo_full    = (fifo_count == DEPTH);
    assign unused_upper = ^io_wr_data;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= io_wr_data[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (io_wr_en && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            baud      <= baud_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        case (state)
            IDLE: begin
                if (pop) begin
                    shift_next = mem[rd_ptr];
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    baud_next = baud + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next    = '0;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end else begin
                    baud_next = baud + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud + BAUD_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // tx is precomputed from the next state so the line comes straight from a flop.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a tx-line monitor decodes frames and
// compares them against a queue of expected bytes; status outputs are checked cycle by cycle.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int BW    = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        io_wr_en = 1'b0;
    logic [BW-1:0] io_wr_data = '0;
    logic        tx, busy, fifo_full, overflow;
    logic [2:0]  fifo_count;

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .BUS_WIDTH   (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .io_wr_en  (io_wr_en),
        .io_wr_data(io_wr_data),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wr_data;
        logic [7:0]  exp_byte;
    } vec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    time        starts[$];
    int         mon_frames = 0;
    bit         mon_busy = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame decoder: 40 samples per frame, one per cycle, aborted by reset.
    initial begin : monitor
        logic [39:0] samples;
        logic [7:0]  got;
        int          bad;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                mon_busy = 1;
                starts.push_back($time);
                samples    = '0;
                samples[0] = tx;
                aborted    = 0;
                for (int n = 1; n < 40; n++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1;
                        break;
                    end
                    samples[n] = tx;
                end
                if (!aborted) begin
                    bad = 0;
                    for (int n = 0; n < 4; n++) if (samples[n] !== 1'b0) bad++;
                    for (int i = 0; i < 8; i++) begin
                        for (int c = 0; c < 4; c++)
                            if (samples[4 + 4*i + c] !== samples[4 + 4*i]) bad++;
                        got[i] = samples[4 + 4*i + 1];
                    end
                    for (int n = 36; n < 40; n++) if (samples[n] !== 1'b1) bad++;
                    check_output("frame_shape", 32'(bad), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("[TB] FAIL unexpected_frame: got byte 0x%0h, expected no frame", got);
                    end else begin
                        check_output("frame_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
                    end
                    mon_frames++;
                end
                mon_busy = 0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while ((busy !== 1'b0 || mon_busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output({name, "_idle"}, {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // One isolated write with exact latency checks around the frame.
    task automatic apply_stimulus(input logic [31:0] data, input logic [7:0] exp);
        @(negedge clk);
        io_wr_en   = 1'b1;
        io_wr_data = data;
        exp_q.push_back(exp);
        @(negedge clk);
        io_wr_en   = 1'b0;
        io_wr_data = $urandom;
        check_output("single_c0_tx", {31'd0, tx}, 32'd1);
        check_output("single_c0_busy", {31'd0, busy}, 32'd1);
        check_output("single_c0_count", {29'd0, fifo_count}, 32'd1);
        @(negedge clk);
        check_output("single_c1_tx", {31'd0, tx}, 32'd0);
        check_output("single_c1_count", {29'd0, fifo_count}, 32'd0);
        repeat (39) @(negedge clk);
        check_output("single_c40_busy", {31'd0, busy}, 32'd1);
        check_output("single_c40_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check_output("single_c41_busy", {31'd0, busy}, 32'd0);
        wait_idle(20, "single");
    endtask

    initial begin : main
        vec_t vecs[5];
        int   base;
        int   low_cnt;
        int   frames_before;

        vecs[0] = '{32'h0000_00A5, 8'hA5};
        vecs[1] = '{32'hFFFF_FF3C, 8'h3C};
        vecs[2] = '{32'h1234_5600, 8'h00};
        vecs[3] = '{32'h0000_00FF, 8'hFF};
        vecs[4] = '{32'hDEAD_BE81, 8'h81};

        #1 rst = 1'b1;
        #2;
        check_output("por_tx", {31'd0, tx}, 32'd1);
        check_output("por_busy", {31'd0, busy}, 32'd0);
        check_output("por_full", {31'd0, fifo_full}, 32'd0);
        check_output("por_count", {29'd0, fifo_count}, 32'd0);
        check_output("por_overflow", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) apply_stimulus(vecs[v].wr_data, vecs[v].exp_byte);

        // Back-to-back writes: frames separated by exactly one idle cycle.
        base = starts.size();
        @(negedge clk);
        io_wr_en = 1'b1; io_wr_data = 32'h11;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        @(negedge clk);
        check_output("b2b_count_e0", {29'd0, fifo_count}, 32'd1);
        io_wr_data = 32'h22;
        @(negedge clk);
        check_output("b2b_count_e1", {29'd0, fifo_count}, 32'd1);
        io_wr_data = 32'h33;
        @(negedge clk);
        check_output("b2b_count_e2", {29'd0, fifo_count}, 32'd2);
        io_wr_en = 1'b0;
        repeat (39) @(negedge clk);
        check_output("b2b_c41_count", {29'd0, fifo_count}, 32'd2);
        check_output("b2b_c41_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check_output("b2b_c42_count", {29'd0, fifo_count}, 32'd1);
        check_output("b2b_c42_tx", {31'd0, tx}, 32'd0);
        repeat (40) @(negedge clk);
        check_output("b2b_c82_count", {29'd0, fifo_count}, 32'd1);
        @(negedge clk);
        check_output("b2b_c83_count", {29'd0, fifo_count}, 32'd0);
        wait_idle(200, "b2b");
        check_output("b2b_frames", 32'(starts.size() - base), 32'd3);
        if (starts.size() >= base + 3) begin
            check_output("b2b_gap1", 32'((starts[base+1] - starts[base]) / 10), 32'd41);
            check_output("b2b_gap2", 32'((starts[base+2] - starts[base+1]) / 10), 32'd41);
        end

        // Write in the final STOP cycle, then a write to a full FIFO on the pop edge.
        base = starts.size();
        @(negedge clk);
        io_wr_en = 1'b1; io_wr_data = 32'h5C;
        exp_q.push_back(8'h5C);
        @(negedge clk);
        io_wr_en = 1'b0;
        repeat (9) @(negedge clk);
        io_wr_en = 1'b1; io_wr_data = 32'h6B; exp_q.push_back(8'h6B);
        @(negedge clk);
        io_wr_data = 32'h7A; exp_q.push_back(8'h7A);
        @(negedge clk);
        io_wr_data = 32'h89; exp_q.push_back(8'h89);
        @(negedge clk);
        io_wr_en = 1'b0;
        check_output("full_c12_count", {29'd0, fifo_count}, 32'd3);
        repeat (28) @(negedge clk);
        check_output("full_c40_tx", {31'd0, tx}, 32'd1);
        check_output("full_c40_count", {29'd0, fifo_count}, 32'd3);
        io_wr_en = 1'b1; io_wr_data = 32'h98; exp_q.push_back(8'h98);
        @(negedge clk);
        check_output("full_c41_count", {29'd0, fifo_count}, 32'd4);
        check_output("full_c41_full", {31'd0, fifo_full}, 32'd1);
        check_output("full_c41_tx", {31'd0, tx}, 32'd1);
        io_wr_data = 32'hA7; exp_q.push_back(8'hA7);
        @(negedge clk);
        io_wr_en = 1'b0;
        check_output("full_c42_count", {29'd0, fifo_count}, 32'd4);
        check_output("full_c42_overflow", {31'd0, overflow}, 32'd0);
        check_output("full_c42_tx", {31'd0, tx}, 32'd0);
        wait_idle(400, "full");
        check_output("full_frames", 32'(starts.size() - base), 32'd6);
        if (starts.size() >= base + 2)
            check_output("full_gap", 32'((starts[base+1] - starts[base]) / 10), 32'd41);
        check_output("full_overflow_end", {31'd0, overflow}, 32'd0);

        // Overflow: six writes in a row, the sixth is dropped.
        base = starts.size();
        @(negedge clk);
        io_wr_en = 1'b1; io_wr_data = 32'h41;
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h41 + i));
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) check_output("ovf_c0_count", {29'd0, fifo_count}, 32'd1);
            if (i == 2) check_output("ovf_c1_count", {29'd0, fifo_count}, 32'd1);
            if (i == 5) begin
                check_output("ovf_c4_count", {29'd0, fifo_count}, 32'd4);
                check_output("ovf_c4_full", {31'd0, fifo_full}, 32'd1);
                check_output("ovf_c4_overflow", {31'd0, overflow}, 32'd0);
            end
            io_wr_data = 32'(32'h41 + i);
        end
        @(negedge clk);
        io_wr_en = 1'b0;
        check_output("ovf_c5_overflow", {31'd0, overflow}, 32'd1);
        check_output("ovf_c5_count", {29'd0, fifo_count}, 32'd4);
        wait_idle(600, "ovf");
        check_output("ovf_frames", 32'(starts.size() - base), 32'd5);
        check_output("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset in the middle of DATA bit 3 abandons the frame and the queue.
        @(negedge clk);
        io_wr_en = 1'b1; io_wr_data = 32'hA5;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            io_wr_data = 32'(i);
        end
        @(negedge clk);
        io_wr_en = 1'b0;
        check_output("rst_pre_count", {29'd0, fifo_count}, 32'd4);
        check_output("rst_pre_overflow", {31'd0, overflow}, 32'd1);
        repeat (13) @(negedge clk);
        check_output("rst_pre_tx", {31'd0, tx}, 32'd0);
        frames_before = mon_frames;
        #2 rst = 1'b1;
        #1;
        check_output("rst_mid_tx", {31'd0, tx}, 32'd1);
        check_output("rst_mid_count", {29'd0, fifo_count}, 32'd0);
        check_output("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_output("rst_mid_overflow", {31'd0, overflow}, 32'd0);
        check_output("rst_mid_full", {31'd0, fifo_full}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        low_cnt = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_cnt++;
        end
        check_output("rst_after_tx_low_cycles", 32'(low_cnt), 32'd0);
        check_output("rst_after_frames", 32'(mon_frames - frames_before), 32'd0);

        apply_stimulus(32'h0000_005A, 8'h5A);
        check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped serial output peripheral that sits directly downstream of the data-memory stage. It consumes each store aimed at the memory-mapped I/O word (the one-cycle write strobe plus store data), buffers the low byte in a small FIFO, and serializes it as 8N1 UART frames on a single tx line. Status outputs let software poll for backpressure.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2 or more.
FIFO_DEPTH, 4, byte entries in the transmit FIFO; must be a power of 2, 2 or more.
BUS_WIDTH, 32, width of the store-data input.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
io_wr_en  input  1  one-cycle strobe; a store to the MMIO address is accepted on this edge.
io_wr_data  input  BUS_WIDTH  store data; only bits [7:0] are transmitted, the rest are ignored.
tx  output  1  serial line; idle high.
busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
fifo_full  output  1  high when fifo_count == FIFO_DEPTH.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes currently queued, excluding the byte being shifted.
overflow  output  1  sticky flag; set when a write is dropped.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0.
  - FSM goes to IDLE; FIFO pointers, baud counter and bit index clear.
  - A partially sent frame is abandoned, not resumed.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Push happens on an edge where io_wr_en=1 and either (count<FIFO_DEPTH) or (a pop occurs on the same edge).
  - Write when full with no same-edge pop: the byte is dropped, count and pointers are unchanged, and overflow is set to 1. overflow clears only on reset.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - fifo_count and fifo_full are registered and reflect the result of the current edge.
- FSM states:
  - IDLE: tx=1. On an edge with count>0, pop the head into an 8-bit shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles. When the baud counter reaches CLKS_PER_BIT-1, go to DATA with bit index 0.
  - DATA: tx = shift_reg[0] (LSB first). Each bit lasts CLKS_PER_BIT cycles; at the end of each bit, shift right and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- tx is driven from a flop; no combinational path from any input to tx.
- Latency:
  - A write on edge k into an empty FIFO with the FSM in IDLE pops on edge k+1; tx falls after edge k+1.
  - Frame length is 10*CLKS_PER_BIT cycles.
  - Exactly one IDLE cycle (tx=1) separates back-to-back frames, so the frame-to-frame period is 10*CLKS_PER_BIT+1 cycles.
- A write arriving during the final STOP cycle is pushed normally and is popped in the following IDLE cycle.
- Baud counter width is $clog2(CLKS_PER_BIT); it resets to 0 on every state transition.

Test Plan:
- Reset values: CLKS_PER_BIT=4. Assert rst mid-frame (during DATA bit 3) -> tx=1, fifo_count=0, busy=0, overflow=0 in the same cycle, before any clock edge. After deassert, tx stays 1 with no residual frame.
- Single byte: write 0x0000_00A5 on edge 0 -> tx low on cycles 1-4, then data bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high for 4 cycles. busy drops after the IDLE edge at cycle 41.
- Upper bits ignored: write 0xFFFF_FF3C -> serialized byte is 0x3C.
- Back-to-back: write 0x11, 0x22, 0x33 on consecutive edges -> three frames with exactly one idle-high cycle between them. fifo_count sequence is 1, 1, 2 on those edges, then decrements on each pop.
- Overflow: FIFO_DEPTH=4. Write 6 bytes on consecutive edges while the first frame is starting -> first byte popped, next 4 queued, 6th dropped. overflow=1 and stays 1 after all frames drain. Transmitted bytes are bytes 1-5 in order.
- Full with simultaneous pop: fill the FIFO to 4 while in STOP, then write on the IDLE pop edge -> write accepted, fifo_count stays 4, overflow stays 0.
